// File: rtl/execute_stage_mc_if.sv
// ID/EX-to-EX/MEM bundle for the multi-cycle execute stage: ID-side operands and
// controls in, registered EX/MEM fields and the stall handshake out.
interface execute_stage_mc_if #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
);
   logic             valid_in;
   logic [WIDTH-1:0] n_pc_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] se_in;
   logic [RA_W-1:0]  rt_in;
   logic [RA_W-1:0]  rd_in;
   logic [1:0]       alu_op;
   logic             alu_src;
   logic             reg_dst;
   logic             branch_in;
   logic             mem_read_in;
   logic             mem_write_in;
   logic             reg_write_in;
   logic             mem_to_reg_in;
   logic             stall_in;
   logic             flush_in;
   logic             stall_out;
   logic [WIDTH-1:0] branch_target;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] mem_write_data;
   logic [RA_W-1:0]  reg_dst_address;
   logic             zero;
   logic             valid_out;
   logic             branch_out;
   logic             mem_read_out;
   logic             mem_write_out;
   logic             reg_write_out;
   logic             mem_to_reg_out;

   modport master (
      output valid_in, n_pc_in, a_in, b_in, se_in, rt_in, rd_in, alu_op, alu_src,
             reg_dst, branch_in, mem_read_in, mem_write_in, reg_write_in,
             mem_to_reg_in, stall_in, flush_in,
      input  stall_out, branch_target, result, mem_write_data, reg_dst_address,
             zero, valid_out, branch_out, mem_read_out, mem_write_out,
             reg_write_out, mem_to_reg_out
   );

   modport slave (
      input  valid_in, n_pc_in, a_in, b_in, se_in, rt_in, rd_in, alu_op, alu_src,
             reg_dst, branch_in, mem_read_in, mem_write_in, reg_write_in,
             mem_to_reg_in, stall_in, flush_in,
      output stall_out, branch_target, result, mem_write_data, reg_dst_address,
             zero, valid_out, branch_out, mem_read_out, mem_write_out,
             reg_write_out, mem_to_reg_out
   );
endinterface

// File: rtl/execute_stage_mc.sv
// MIPS execute stage with EX/MEM register, stall/flush handling and an
// iterative shift-add multu unit writing HI/LO.
module execute_stage_mc #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
) (
   input logic               clk,
   input logic               reset,
   execute_stage_mc_if.slave ex
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   logic [1:0]         state_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;

   logic [WIDTH-1:0]   b_op;
   logic [5:0]         funct;
   logic               is_multu;
   logic               slt_bit;
   logic [WIDTH-1:0]   alu_res;
   logic [2*WIDTH-1:0] acc_next;
   logic               capture_ok;

   assign b_op     = ex.alu_src ? ex.se_in : ex.b_in;
   assign funct    = ex.se_in[5:0];
   assign is_multu = (ex.alu_op == 2'b10) && (funct == F_MULTU);
   assign slt_bit  = $signed(ex.a_in) < $signed(b_op);
   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   always_comb begin
      alu_res = '0;
      case (ex.alu_op)
         2'b00: alu_res = ex.a_in + b_op;
         2'b01: alu_res = ex.a_in - b_op;
         2'b11: alu_res = ex.a_in | b_op;
         default: begin
            case (funct)
               F_ADD:   alu_res = ex.a_in + b_op;
               F_SUB:   alu_res = ex.a_in - b_op;
               F_AND:   alu_res = ex.a_in & b_op;
               F_OR:    alu_res = ex.a_in | b_op;
               F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
               F_MFHI:  alu_res = hi_reg;
               F_MFLO:  alu_res = lo_reg;
               default: alu_res = '0;
            endcase
         end
      endcase
   end

   // Flush always releases the hold so the squash can propagate this cycle.
   assign ex.stall_out = !ex.flush_in &&
                         (ex.stall_in ||
                          (state_reg == S_IDLE && ex.valid_in && is_multu) ||
                          (state_reg == S_BUSY));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         count_reg  <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (ex.valid_in && is_multu && !ex.flush_in) begin
                  state_reg  <= S_BUSY;
                  mcand_reg  <= {{WIDTH{1'b0}}, ex.a_in};
                  mplier_reg <= ex.b_in;
                  acc_reg    <= '0;
                  count_reg  <= '0;
               end
            end
            S_BUSY: begin
               if (ex.flush_in) begin
                  state_reg <= S_IDLE;
               end else begin
                  acc_reg    <= acc_next;
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
                  count_reg  <= count_reg + CNT_W'(1);
                  if (count_reg == LAST_STEP) state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               if (ex.flush_in) begin
                  state_reg <= S_IDLE;
               end else if (!ex.stall_in) begin
                  {hi_reg, lo_reg} <= acc_reg;
                  state_reg        <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // A multu reaches EX/MEM only once its product is complete.
   assign capture_ok = !is_multu || (state_reg == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex.valid_out       <= 1'b0;
         ex.branch_out      <= 1'b0;
         ex.mem_read_out    <= 1'b0;
         ex.mem_write_out   <= 1'b0;
         ex.reg_write_out   <= 1'b0;
         ex.mem_to_reg_out  <= 1'b0;
         ex.zero            <= 1'b0;
         ex.result          <= '0;
         ex.branch_target   <= '0;
         ex.mem_write_data  <= '0;
         ex.reg_dst_address <= '0;
      end else if (ex.flush_in || (!ex.stall_in && (!ex.valid_in || !capture_ok))) begin
         ex.valid_out       <= 1'b0;
         ex.branch_out      <= 1'b0;
         ex.mem_read_out    <= 1'b0;
         ex.mem_write_out   <= 1'b0;
         ex.reg_write_out   <= 1'b0;
         ex.mem_to_reg_out  <= 1'b0;
         ex.zero            <= 1'b0;
         ex.result          <= '0;
         ex.branch_target   <= '0;
         ex.mem_write_data  <= '0;
         ex.reg_dst_address <= '0;
      end else if (!ex.stall_in) begin
         ex.valid_out       <= 1'b1;
         ex.branch_out      <= ex.branch_in;
         ex.mem_read_out    <= ex.mem_read_in;
         ex.mem_write_out   <= ex.mem_write_in;
         ex.reg_write_out   <= ex.reg_write_in && !is_multu;
         ex.mem_to_reg_out  <= ex.mem_to_reg_in;
         ex.zero            <= (alu_res == '0);
         ex.result          <= alu_res;
         ex.branch_target   <= ex.n_pc_in + (ex.se_in << 2);
         ex.mem_write_data  <= ex.b_in;
         ex.reg_dst_address <= ex.reg_dst ? ex.rd_in : ex.rt_in;
      end
   end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: ALU vector table plus multu/stall/flush/reset sequences.
module tb_execute_stage_mc;
   localparam int W  = 32;
   localparam int RA = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   execute_stage_mc_if #(.WIDTH(W), .RA_W(RA)) bus ();
   execute_stage_mc #(.WIDTH(W), .RA_W(RA)) dut (.clk(clk), .reset(reset), .ex(bus));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, se, npc;
      logic        src, rdst;
      logic [4:0]  rt, rd, ctl;
      logic [31:0] exp_res, exp_bt;
      logic        exp_zero;
      logic [4:0]  exp_dst;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.valid_in = 0; bus.n_pc_in = '0; bus.a_in = '0; bus.b_in = '0; bus.se_in = '0;
      bus.rt_in = '0; bus.rd_in = '0; bus.alu_op = 2'b00; bus.alu_src = 0; bus.reg_dst = 0;
      bus.branch_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0; bus.reg_write_in = 0;
      bus.mem_to_reg_in = 0; bus.stall_in = 0; bus.flush_in = 0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] se, input logic [31:0] npc, input logic src,
                        input logic rdst, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] ctl);
      bus.valid_in = 1; bus.alu_op = op; bus.a_in = a; bus.b_in = b; bus.se_in = se;
      bus.n_pc_in = npc; bus.alu_src = src; bus.reg_dst = rdst; bus.rt_in = rt; bus.rd_in = rd;
      {bus.branch_in, bus.mem_read_in, bus.mem_write_in, bus.reg_write_in, bus.mem_to_reg_in} = ctl;
   endtask

   task automatic issue_multu(input logic [31:0] a, input logic [31:0] b);
      issue(2'b10, a, b, 32'h19, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8, 5'b00010);
   endtask

   task automatic read_hilo(input string name, input logic [5:0] f, input logic [31:0] exp);
      issue(2'b10, 32'h0, 32'h0, {26'h0, f}, 32'h0, 1'b0, 1'b1, 5'd0, 5'd2, 5'b00010);
      tick();
      chk(name, 64'(bus.result), 64'(exp));
      $display("%s: result=0x%08h", name, bus.result);
   endtask

   function automatic logic [4:0] ctl_out();
      return {bus.branch_out, bus.mem_read_out, bus.mem_write_out, bus.reg_write_out, bus.mem_to_reg_out};
   endfunction

   initial begin
      int n;
      //           op     a             b             se            npc         src rdst rt  rd  ctl       res           bt            z  dst
      vecs[0]  = '{2'b10, 32'd7,        32'hFFFFFFF9, 32'h20,       32'h0,      0,  1,   3,  9,  5'b00010, 32'h0,        32'h80,       1, 9};
      vecs[1]  = '{2'b01, 32'd5,        32'd5,        32'hFFFFFFFF, 32'h100,    0,  0,   4,  7,  5'b10000, 32'h0,        32'hFC,       1, 4};
      vecs[2]  = '{2'b10, 32'd10,       32'd3,        32'h22,       32'h10,     0,  1,   1,  5,  5'b00010, 32'd7,        32'h98,       0, 5};
      vecs[3]  = '{2'b10, 32'hF0F0FFFF, 32'h0FF000FF, 32'h24,       32'h0,      0,  1,   1,  6,  5'b00010, 32'h00F000FF, 32'h90,       0, 6};
      vecs[4]  = '{2'b10, 32'h1200,     32'h34,       32'h25,       32'h0,      0,  1,   1,  7,  5'b00010, 32'h1234,     32'h94,       0, 7};
      vecs[5]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'h2A,       32'h0,      0,  1,   1,  10, 5'b00010, 32'd1,        32'hA8,       0, 10};
      vecs[6]  = '{2'b10, 32'd5,        32'hFFFFFFFD, 32'h2A,       32'h0,      0,  1,   1,  11, 5'b00010, 32'd0,        32'hA8,       1, 11};
      vecs[7]  = '{2'b00, 32'h1000,     32'hDEAD,     32'h10,       32'h0,      1,  0,   12, 2,  5'b01100, 32'h1010,     32'h40,       0, 12};
      vecs[8]  = '{2'b11, 32'hA0,       32'h05,       32'h0,        32'h4,      0,  0,   13, 2,  5'b00011, 32'hA5,       32'h4,        0, 13};
      vecs[9]  = '{2'b10, 32'd3,        32'd4,        32'h3F,       32'h0,      0,  1,   1,  14, 5'b00010, 32'h0,        32'hFC,       1, 14};
      vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,      0,  0,   15, 2,  5'b00010, 32'h0,        32'h0,        1, 15};

      idle_inputs();
      reset = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1;
      tick();
      chk("reset_valid", 64'(bus.valid_out), 64'(0));
      chk("reset_result", 64'(bus.result), 64'(0));
      chk("reset_bt", 64'(bus.branch_target), 64'(0));
      chk("reset_zero", 64'(bus.zero), 64'(0));
      chk("reset_ctl", 64'(ctl_out()), 64'(0));
      chk("reset_stall_out", 64'(bus.stall_out), 64'(0));
      $display("reset: valid=%0b result=0x%0h stall_out=%0b", bus.valid_out, bus.result, bus.stall_out);

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].se, vecs[i].npc, vecs[i].src,
               vecs[i].rdst, vecs[i].rt, vecs[i].rd, vecs[i].ctl);
         #1;
         chk($sformatf("v%0d_stall_out", i), 64'(bus.stall_out), 64'(0));
         tick();
         chk($sformatf("v%0d_result", i), 64'(bus.result), 64'(vecs[i].exp_res));
         chk($sformatf("v%0d_zero", i), 64'(bus.zero), 64'(vecs[i].exp_zero));
         chk($sformatf("v%0d_dst", i), 64'(bus.reg_dst_address), 64'(vecs[i].exp_dst));
         chk($sformatf("v%0d_bt", i), 64'(bus.branch_target), 64'(vecs[i].exp_bt));
         chk($sformatf("v%0d_mwd", i), 64'(bus.mem_write_data), 64'(vecs[i].b));
         chk($sformatf("v%0d_valid", i), 64'(bus.valid_out), 64'(1));
         chk($sformatf("v%0d_ctl", i), 64'(ctl_out()), 64'(vecs[i].ctl));
         $display("vec %0d: result=0x%08h zero=%0b dst=%0d bt=0x%08h", i, bus.result, bus.zero,
                  bus.reg_dst_address, bus.branch_target);
      end

      // multu 0xFFFFFFFF * 2, then read LO/HI back-to-back
      issue_multu(32'hFFFFFFFF, 32'd2);
      #1;
      n = 0;
      while (bus.stall_out && n < 100) begin
         n++;
         tick();
      end
      chk("multu_stall_cycles", 64'(n), 64'(33));
      chk("multu_busy_bubble", 64'(bus.valid_out), 64'(0));
      tick();
      chk("multu_capture_valid", 64'(bus.valid_out), 64'(1));
      chk("multu_capture_regwrite", 64'(bus.reg_write_out), 64'(0));
      $display("multu: stall cycles=%0d valid=%0b reg_write=%0b", n, bus.valid_out, bus.reg_write_out);
      read_hilo("mflo_1", 6'b010010, 32'hFFFFFFFE);
      read_hilo("mfhi_1", 6'b010000, 32'h1);

      // stall_in held from issue through three DONE cycles: EX/MEM keeps the prior add
      issue(2'b00, 32'h50, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd0, 5'b00010);
      tick();
      chk("pre_add_result", 64'(bus.result), 64'(32'h55));
      issue_multu(32'd3, 32'd5);
      bus.stall_in = 1;
      repeat (33) tick();
      chk("hold_at_done_result", 64'(bus.result), 64'(32'h55));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("hold%0d_result", i), 64'(bus.result), 64'(32'h55));
         chk($sformatf("hold%0d_valid", i), 64'(bus.valid_out), 64'(1));
         chk($sformatf("hold%0d_stall_out", i), 64'(bus.stall_out), 64'(1));
         $display("hold %0d: result=0x%0h valid=%0b stall_out=%0b", i, bus.result, bus.valid_out, bus.stall_out);
      end
      bus.stall_in = 0;
      #1;
      chk("done_after_hold_stall_out", 64'(bus.stall_out), 64'(0));
      tick();
      chk("hold_release_valid", 64'(bus.valid_out), 64'(1));
      chk("hold_release_regwrite", 64'(bus.reg_write_out), 64'(0));
      read_hilo("mflo_2", 6'b010010, 32'd15);
      read_hilo("mfhi_2", 6'b010000, 32'd0);

      // flush (together with stall_in) in BUSY cycle 10 aborts the multiply
      issue_multu(32'd7, 32'd9);
      repeat (10) tick();
      chk("flush_pre_stall_out", 64'(bus.stall_out), 64'(1));
      bus.flush_in = 1;
      bus.stall_in = 1;
      #1;
      chk("flush_stall_out", 64'(bus.stall_out), 64'(0));
      tick();
      chk("flush_bubble_valid", 64'(bus.valid_out), 64'(0));
      chk("flush_bubble_ctl", 64'(ctl_out()), 64'(0));
      idle_inputs();
      #1;
      chk("flush_idle_stall_out", 64'(bus.stall_out), 64'(0));
      $display("flush: valid=%0b stall_out=%0b", bus.valid_out, bus.stall_out);
      read_hilo("mflo_flush", 6'b010010, 32'd15);
      read_hilo("mfhi_flush", 6'b010000, 32'd0);

      // asynchronous reset mid-multiply clears HI/LO
      issue(2'b00, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd0, 5'b00010);
      tick();
      issue_multu(32'd3, 32'd7);
      repeat (5) tick();
      #2 reset = 0;
      #1;
      chk("areset_valid", 64'(bus.valid_out), 64'(0));
      idle_inputs();
      @(negedge clk);
      reset = 1;
      #1;
      chk("areset_stall_out", 64'(bus.stall_out), 64'(0));
      read_hilo("mflo_reset", 6'b010010, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
